// File: rtl/seven_seg_scanner.sv
// Four-digit common-anode seven-segment scanner with inter-digit blanking,
// leading-zero suppression and frame-aligned swapping of new display values.
module seven_seg_scanner #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter bit LZ_BLANK     = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  output logic [3:0]  digit_data,
  input  logic [7:0]  seg_in,
  output logic [7:0]  seg_out,
  output logic [3:0]  an,
  output logic        frame_start
);

  localparam int TW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic {BLANK, SHOW} phase_t;

  logic [TW-1:0] tick, tick_nxt;
  logic [1:0]    idx, idx_nxt;
  logic [15:0]   shadow_val, active_val, active_val_nxt;
  logic [3:0]    shadow_dp, active_dp, active_dp_nxt;
  logic          pending, pending_nxt;
  logic          wrap, boundary, lz_suppress;
  phase_t        phase_nxt;
  logic [3:0]    an_nxt;

  // Anodes are registered from next-state values so they line up with tick/idx.
  // NOTE: every variable gets a default at the top of always_comb, so no latch is inferred.
  always_comb begin
    wrap           = (tick == TW'(REFRESH_DIV - 1));
    tick_nxt       = wrap ? '0 : tick + 1'b1;
    idx_nxt        = wrap ? idx + 2'd1 : idx;
    boundary       = wrap && (idx == 2'd3);
    active_val_nxt = active_val;
    active_dp_nxt  = active_dp;
    pending_nxt    = pending;

    if (boundary) begin
      if (load) begin
        active_val_nxt = value_in;
        active_dp_nxt  = dp_in;
      end else if (pending) begin
        active_val_nxt = shadow_val;
        active_dp_nxt  = shadow_dp;
      end
      pending_nxt = 1'b0;
    end else if (load) begin
      pending_nxt = 1'b1;
    end

    unique case (idx_nxt)
      2'd1:    lz_suppress = LZ_BLANK && (active_val_nxt[15:4]  == '0);
      2'd2:    lz_suppress = LZ_BLANK && (active_val_nxt[15:8]  == '0);
      2'd3:    lz_suppress = LZ_BLANK && (active_val_nxt[15:12] == '0);
      default: lz_suppress = 1'b0;
    endcase

    phase_nxt = (tick_nxt < TW'(BLANK_CYCLES)) ? BLANK : SHOW;
    an_nxt    = (phase_nxt == BLANK || !enable || lz_suppress)
              ? 4'b1111 : ~(4'b0001 << idx_nxt);
  end

  assign digit_data = active_val[{idx, 2'b00} +: 4];

  // NOTE: sequential state uses non-blocking assignments only, so all registers
  // sample the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick        <= '0;
      idx         <= '0;
      shadow_val  <= '0;
      shadow_dp   <= '0;
      active_val  <= '0;
      active_dp   <= '0;
      pending     <= 1'b0;
      an          <= 4'b1111;
      seg_out     <= 8'hFF;
      frame_start <= 1'b0;
    end else begin
      tick        <= tick_nxt;
      idx         <= idx_nxt;
      active_val  <= active_val_nxt;
      active_dp   <= active_dp_nxt;
      pending     <= pending_nxt;
      an          <= an_nxt;
      frame_start <= boundary;
      // Decimal point is active-low: a lit dp pulls the bit to 0.
      seg_out     <= {seg_in[7:1], seg_in[0] & ~active_dp[idx]};
      if (load) begin
        shadow_val <= value_in;
        shadow_dp  <= dp_in;
      end
    end
  end

endmodule
